// File: rtl/escaner_teclado.sv
// escaner_teclado: matrix-keypad scanner with full-scan debounce and single-cycle press events
module escaner_teclado #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int MAPA = 1,
  localparam int CW = $clog2(ROWS * COLS),
  localparam int TW = (MAPA != 0) ? 4 : CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] filas_n,
  output logic [COLS-1:0] columnas_n,
  output logic [CW-1:0]   codigo,
  output logic [TW-1:0]   tecla,
  output logic            tecla_valida,
  output logic            tecla_presionada
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int LW = $clog2(COLS);
  localparam int NW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DEB  = 2'd1;
  localparam logic [1:0] PRES = 2'd2;
  localparam logic [1:0] REL  = 2'd3;
  logic [ROWS-1:0] s1_q, s2_q;
  logic [DW-1:0]   div_q;
  logic [LW-1:0]   col_q;
  logic [1:0]      acc_n_q, base_n, tot_n;
  logic [CW-1:0]   acc_k_q, base_k, tot_k, row_k;
  logic [3:0]      col_n;
  logic            sample, last_col, scan_end, one, none, accept;
  logic [1:0]      state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]   cand_q, cand_d, codigo_q;
  logic [TW-1:0]   tecla_q, map_k;
  logic            valid_q;
  assign sample   = div_q == DW'(SCAN_DIV - 1);
  assign last_col = col_q == LW'(COLS - 1);
  assign scan_end = sample && last_col;
  assign columnas_n = ~(COLS'(1) << col_q);
  // per-column press count and lowest pressed row of the column being sampled
  always_comb begin
    col_n = '0;
    row_k = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      if (!s2_q[r]) begin
        col_n = col_n + 4'd1;
        row_k = CW'(r * COLS) + CW'(col_q);
      end
  end
  // running scan result: 0 none, 1 exactly one key (acc_k_q), 2 multiple keys
  assign base_n = (col_q == '0) ? 2'd0 : acc_n_q;
  assign base_k = (col_q == '0) ? '0 : acc_k_q;
  assign tot_n  = (base_n == 2'd2 || col_n > 4'd1 || (base_n == 2'd1 && col_n == 4'd1)) ? 2'd2 : base_n | col_n[1:0];
  assign tot_k  = (base_n == 2'd0) ? row_k : base_k;
  assign one    = tot_n == 2'd1;
  assign none   = tot_n == 2'd0;
  assign cnt_inc = cnt_q + NW'(1);
  generate
    if (MAPA != 0) begin : g_map
      localparam logic [63:0] MAP = 64'hDF0EC987B654A321;
      assign map_k = MAP[{tot_k, 2'b00} +: 4];
    end else begin : g_raw
      assign map_k = tot_k;
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q    <= '1;
      s2_q    <= '1;
      div_q   <= '0;
      col_q   <= '0;
      acc_n_q <= '0;
      acc_k_q <= '0;
    end else begin
      s1_q  <= filas_n;
      s2_q  <= s1_q;
      div_q <= sample ? '0 : div_q + DW'(1);
      if (sample) begin
        col_q   <= last_col ? '0 : col_q + LW'(1);
        acc_n_q <= tot_n;
        acc_k_q <= tot_k;
      end
    end
  assign accept = scan_end && one &&
                  ((state_q == IDLE) ? (DEBOUNCE == 1)
                                     : (state_q == DEB && tot_k == cand_q && cnt_inc == NW'(DEBOUNCE)));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (scan_end)
      case (state_q)
        IDLE: if (one) begin
          state_d = (DEBOUNCE == 1) ? PRES : DEB;
          cnt_d   = NW'(1);
          cand_d  = tot_k;
        end
        DEB: if (!one) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tot_k != cand_q) begin
          cand_d = tot_k;
          cnt_d  = NW'(1);
        end else begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == NW'(DEBOUNCE)) ? PRES : DEB;
        end
        PRES: if (none) begin
          state_d = (DEBOUNCE == 1) ? IDLE : REL;
          cnt_d   = (DEBOUNCE == 1) ? '0 : NW'(1);
        end
        REL: if (!none) state_d = PRES;
        else begin
          state_d = (cnt_inc == NW'(DEBOUNCE)) ? IDLE : REL;
          cnt_d   = (cnt_inc == NW'(DEBOUNCE)) ? '0 : cnt_inc;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      codigo_q <= '0;
      tecla_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      codigo_q <= accept ? tot_k : codigo_q;
      tecla_q  <= accept ? map_k : tecla_q;
      valid_q  <= accept;
    end
  assign codigo           = codigo_q;
  assign tecla            = tecla_q;
  assign tecla_valida     = valid_q;
  assign tecla_presionada = state_q == PRES || state_q == REL;
endmodule
